// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stop levels, stall-bus
// width, the two stall patterns and the multi-cycle FSM state encodings.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_W = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Bit order: {WB, MEM/WB, EX/MEM, ID/EX, IF/ID, PC}
    localparam logic [STALL_W-1:0] STALL_NONE = '0;
    localparam logic [STALL_W-1:0] STALL_ID   = {NO_STOP, NO_STOP, NO_STOP, STOP, STOP, STOP};
    localparam logic [STALL_W-1:0] STALL_EX   = {NO_STOP, NO_STOP, STOP, STOP, STOP, STOP};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating stall-cycle counter; only instantiated by pipe_ctrl when
// PIPE_CTRL_PERF_EN is defined.
module pipe_perf_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count qualifying cycles, holding at all-ones once reached
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall controller with a multi-cycle EX operation sequencer.
// Optional stall-cycle performance counter enabled by PIPE_CTRL_PERF_EN;
// without it stall_cycles is tied to zero and no counter is built.
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter int unsigned MC_CNT_W = 6,
    parameter int unsigned PERF_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_id,
    input  logic                stallreq_ex,
    input  logic                mc_start,
    input  logic [MC_CNT_W-1:0] mc_cycles,
    input  logic                mc_flush,
    output logic [STALL_W-1:0]  stall,
    output logic                mc_busy,
    output logic                mc_done,
    output logic [PERF_W-1:0]   stall_cycles
);

    state_t              state;
    state_t              state_next;
    logic [MC_CNT_W-1:0] cnt;
    logic [MC_CNT_W-1:0] cnt_next;

    // State and down-counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: start only from IDLE, flush only from RUN (and beats count==1)
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (mc_start) begin
                    if (mc_cycles != '0) begin
                        state_next = ST_RUN;
                        cnt_next   = mc_cycles;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (mc_flush) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt == MC_CNT_W'(1)) begin
                    state_next = ST_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - MC_CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs: status decoded from state, stall vector masked while in reset
    always_comb begin
        mc_busy = (state == ST_RUN);
        mc_done = (state == ST_DONE);
        stall   = STALL_NONE;
        if (!rst) begin
            if ((state == ST_RUN) || stallreq_ex) begin
                stall = STALL_EX;
            end else if (stallreq_id) begin
                stall = STALL_ID;
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    pipe_perf_cnt #(
        .W(PERF_W)
    ) u_perf_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall[0]),
        .count (stall_cycles)
    );
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MC_CNT_W, default 6, width of the multi-cycle length field and down-counter.
REQ-002 SHALL have parameter PERF_W, default 32, width of the stall-cycle performance counter.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port stallreq_id  input  1  ID-stage stall request, level, e.g. load-use.
REQ-006 SHALL have port stallreq_ex  input  1  EX-stage stall request, level.
REQ-007 SHALL have port mc_start  input  1  single-cycle pulse; EX begins a multi-cycle operation.
REQ-008 SHALL have port mc_cycles  input  MC_CNT_W  extra cycles required, sampled only with mc_start.
REQ-009 SHALL have port mc_flush  input  1  abort the multi-cycle operation in progress.
REQ-010 SHALL have port stall  output  6  stall vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = Stop.
REQ-011 SHALL have port mc_busy  output  1  high while a multi-cycle operation is counting.
REQ-012 SHALL have port mc_done  output  1  single-cycle completion pulse.
REQ-013 SHALL have port stall_cycles  output  PERF_W  count of cycles with stall[0]==1.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 In IDLE, mc_start with mc_cycles>=1 SHALL load the counter with mc_cycles and enter RUN.
REQ-016 In IDLE, mc_start with mc_cycles==0 SHALL enter DONE directly.
REQ-017 In RUN, the counter SHALL decrement each cycle; at counter==1 the next state SHALL be DONE.
REQ-018 DONE SHALL last exactly one cycle, assert mc_done, then return to IDLE.
REQ-019 mc_start in RUN or DONE SHALL be ignored.
REQ-020 mc_flush in RUN SHALL force IDLE on the next edge, with no mc_done; flush has priority over the counter reaching 1.
REQ-021 mc_flush in IDLE or DONE SHALL have no effect.
REQ-022 mc_busy SHALL equal (state==RUN).
REQ-023 Latency: for mc_start at cycle T with N>=1, mc_busy SHALL be high in cycles T+1..T+N and mc_done high in T+N+1.
REQ-024 stall SHALL be combinational; 6'b001111 if state==RUN or stallreq_ex==1.
REQ-025 Otherwise stall SHALL be 6'b000111 if stallreq_id==1, else 6'b000000.
REQ-026 The EX-level pattern SHALL win when both stall requests are active.

Reset
REQ-027 On rst==1 at a clock edge: state IDLE, counter 0, mc_busy 0, mc_done 0, stall_cycles 0.
REQ-028 stall SHALL be 6'b000000 during reset regardless of stallreq_id and stallreq_ex.
REQ-029 Reset in RUN SHALL abort the operation with no mc_done pulse.

Configuration
REQ-030 Macro PIPE_CTRL_PERF_EN defined: stall_cycles SHALL increment on every non-reset cycle with stall[0]==1 and saturate at all-ones.
REQ-031 Macro PIPE_CTRL_PERF_EN undefined: stall_cycles SHALL be tied to 0 and no counter flops SHALL exist.

Structure
REQ-032 Shared defines.v SHALL hold Stop/NoStop, the StallBus width, both stall patterns and the FSM state encodings.
REQ-033 The performance counter SHALL be sub-module pipe_perf_cnt, instantiated only under PIPE_CTRL_PERF_EN.

Verification
REQ-034 Reset, then idle inputs -> stall=000000, mc_busy=0, mc_done=0, stall_cycles=0.
REQ-035 stallreq_id=1 and stallreq_ex=1 in the same cycle -> stall=001111; drop stallreq_ex -> stall=000111.
REQ-036 mc_start, mc_cycles=3 at T -> stall=001111 and mc_busy=1 in T+1..T+3; mc_done=1, stall=000000 in T+4.
REQ-037 mc_cycles=0 -> mc_done at T+1 with no stall; a second mc_start in RUN -> ignored, original count completes.
REQ-038 mc_cycles=5 with mc_flush at T+2 -> IDLE at T+3, no mc_done; rst at T+2 in another run -> same, stall=000000.
REQ-039 PIPE_CTRL_PERF_EN defined with 10 stalled cycles -> stall_cycles=10; undefined -> stall_cycles stays 0.
